// File: rtl/dot_scan_if.sv
// Dot scan controller bus.
// Groups the host configuration and handshake, the dot memory read path and
// the actuator drive into one bundle.
//   master : the scan controller (drives selects, drive and status outputs)
//   slave  : host + dot memory + actuator side
interface dot_scan_if #(
    parameter int MEM_ADDRESS_LENGTH = 6,
    parameter int DWELL_WIDTH        = 16
);
    logic                          start;
    logic                          stop;
    logic                          continuous;
    logic [MEM_ADDRESS_LENGTH-1:0] row_last;
    logic [MEM_ADDRESS_LENGTH-1:0] col_last;
    logic [DWELL_WIDTH-1:0]        dwell_cycles;
    logic [DWELL_WIDTH-1:0]        gap_cycles;
    logic                          col_mode;
    logic                          firing_bit;
    logic                          firing_data;
    logic [MEM_ADDRESS_LENGTH-1:0] row_select;
    logic [MEM_ADDRESS_LENGTH-1:0] col_select;
    logic                          row_col_select;
    logic                          drive_out;
    logic                          drive_phase;
    logic                          busy;
    logic                          frame_done;

    modport master (
        input  start, stop, continuous, row_last, col_last, dwell_cycles,
               gap_cycles, col_mode, firing_bit, firing_data,
        output row_select, col_select, row_col_select, drive_out,
               drive_phase, busy, frame_done
    );

    modport slave (
        output start, stop, continuous, row_last, col_last, dwell_cycles,
               gap_cycles, col_mode, firing_bit, firing_data,
        input  row_select, col_select, row_col_select, drive_out,
               drive_phase, busy, frame_done
    );
endinterface

// File: rtl/dot_scan_controller.sv
// Dot matrix scan sequencer.
// Walks row/col selects over a ROWS x COLS window; per dot it settles the
// memory read for one cycle, fires for max(dwell,1) cycles, then waits gap.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high
//   bus    : dot_scan_if master (config/handshake in, selects/drive/status out)
//
// state  | meaning
// IDLE   | not scanning, selects parked at (0,0)
// SETTLE | one cycle for the memory read path to settle on the selects
// FIRE   | drive_out held with the sampled firing_bit for the dwell time
// GAP    | drive_out low for gap_cycles before advancing
module dot_scan_controller #(
    parameter int MEM_ADDRESS_LENGTH = 6,
    parameter int DWELL_WIDTH        = 16
) (
    input  logic      clock,
    input  logic      reset,
    dot_scan_if.master bus
);
    localparam int AW = MEM_ADDRESS_LENGTH;
    localparam int DW = DWELL_WIDTH;
    localparam logic [AW-1:0] IDX_ONE = AW'(1);
    localparam logic [DW-1:0] CNT_ONE = DW'(1);

    typedef enum logic [1:0] {IDLE, SETTLE, FIRE, GAP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] row_q, row_d, col_q, col_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          drive_out_q, drive_out_d;
    logic          drive_phase_q, drive_phase_d;
    logic          frame_done_q, frame_done_d;
    logic [AW-1:0] row_last_q, row_last_d, col_last_q, col_last_d;
    logic [DW-1:0] dwell_q, dwell_d, gap_q, gap_d;
    logic          continuous_q, continuous_d;
    logic          col_mode_q, col_mode_d;
    logic          advance;
    logic [DW-1:0] dwell_eff;

    assign dwell_eff = (dwell_q == '0) ? CNT_ONE : dwell_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            cnt_q         <= '0;
            drive_out_q   <= 1'b0;
            drive_phase_q <= 1'b0;
            frame_done_q  <= 1'b0;
            row_last_q    <= '0;
            col_last_q    <= '0;
            dwell_q       <= '0;
            gap_q         <= '0;
            continuous_q  <= 1'b0;
            col_mode_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            drive_out_q   <= drive_out_d;
            drive_phase_q <= drive_phase_d;
            frame_done_q  <= frame_done_d;
            row_last_q    <= row_last_d;
            col_last_q    <= col_last_d;
            dwell_q       <= dwell_d;
            gap_q         <= gap_d;
            continuous_q  <= continuous_d;
            col_mode_q    <= col_mode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        cnt_d         = cnt_q;
        drive_out_d   = drive_out_q;
        drive_phase_d = drive_phase_q;
        frame_done_d  = 1'b0;
        row_last_d    = row_last_q;
        col_last_d    = col_last_q;
        dwell_d       = dwell_q;
        gap_d         = gap_q;
        continuous_d  = continuous_q;
        col_mode_d    = col_mode_q;
        advance       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    row_last_d   = bus.row_last;
                    col_last_d   = bus.col_last;
                    dwell_d      = bus.dwell_cycles;
                    gap_d        = bus.gap_cycles;
                    continuous_d = bus.continuous;
                    col_mode_d   = bus.col_mode;
                    row_d        = '0;
                    col_d        = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                drive_out_d   = bus.firing_bit;
                drive_phase_d = bus.firing_data;
                cnt_d         = dwell_eff;
                state_d       = FIRE;
            end
            FIRE: begin
                if (cnt_q <= CNT_ONE) begin
                    drive_out_d = 1'b0;
                    if (gap_q != '0) begin
                        cnt_d   = gap_q;
                        state_d = GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q <= CNT_ONE) advance = 1'b1;
                else                  cnt_d = cnt_q - CNT_ONE;
            end
            default: state_d = IDLE;
        endcase

        // Advance shares the edge that ends the dot's last FIRE/GAP cycle.
        if (advance) begin
            drive_out_d   = 1'b0;
            drive_phase_d = 1'b0;
            cnt_d         = '0;
            state_d       = SETTLE;
            if (col_q < col_last_q) begin
                col_d = col_q + IDX_ONE;
            end else begin
                col_d = '0;
                if (row_q < row_last_q) begin
                    row_d = row_q + IDX_ONE;
                end else begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                    if (!continuous_q) state_d = IDLE;
                end
            end
        end

        // Abort wins over everything, including the end-of-frame pulse.
        if (bus.stop && state_q != IDLE) begin
            state_d       = IDLE;
            row_d         = '0;
            col_d         = '0;
            cnt_d         = '0;
            drive_out_d   = 1'b0;
            drive_phase_d = 1'b0;
            frame_done_d  = 1'b0;
        end
    end

    assign bus.row_select     = row_q;
    assign bus.col_select     = col_q;
    assign bus.row_col_select = col_mode_q;
    assign bus.drive_out      = drive_out_q;
    assign bus.drive_phase    = drive_phase_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.frame_done     = frame_done_q;
endmodule

// File: tb/tb_dot_scan_controller.sv
module tb_dot_scan_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Dot memory model: one firing_bit location and one firing_data location.
    bit bit_en = 0, data_en = 0;
    int bit_row = 0, bit_col = 0, data_row = 0, data_col = 0;

    dot_scan_if #(.MEM_ADDRESS_LENGTH(6), .DWELL_WIDTH(16)) bus ();

    dot_scan_controller #(.MEM_ADDRESS_LENGTH(6), .DWELL_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always_comb begin
        bus.firing_bit  = bit_en && (int'(bus.row_select) == bit_row) && (int'(bus.col_select) == bit_col);
        bus.firing_data = data_en && (int'(bus.row_select) == data_row) && (int'(bus.col_select) == data_col);
    end

    function automatic logic [16:0] pack(int r, int c, bit drv, bit ph, bit bsy, bit fd, bit rcs);
        logic [5:0] r6, c6;
        r6 = 6'(r);
        c6 = 6'(c);
        return {r6, c6, drv, ph, bsy, fd, rcs};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.row_select, bus.col_select, bus.drive_out, bus.drive_phase,
                bus.busy, bus.frame_done, bus.row_col_select};
    endfunction

    // Expected outputs k cycles after the start edge of a single (non-continuous) pass, dwell >= 1.
    function automatic logic [16:0] model(int k, int dwell, int gap, int cl, int rl, bit rcs);
        int per, n, d, p, r, c;
        bit drv, ph;
        per = 1 + dwell + gap;
        n   = (rl + 1) * (cl + 1);
        d   = k / per;
        p   = k % per;
        if (d >= n) return pack(0, 0, 0, 0, 0, (k == n * per), rcs);
        r   = d / (cl + 1);
        c   = d % (cl + 1);
        drv = (p >= 1) && (p <= dwell) && bit_en && (r == bit_row) && (c == bit_col);
        ph  = (p >= 1) && data_en && (r == data_row) && (c == data_col);
        return pack(r, c, drv, ph, 1, 0, rcs);
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (row,col,drv,ph,busy,fd,rcs)", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.continuous = 0;
        bus.row_last = '0; bus.col_last = '0;
        bus.dwell_cycles = '0; bus.gap_cycles = '0; bus.col_mode = 0;

        step(); step();
        reset = 0;
        chk("reset", observed(), pack(0, 0, 0, 0, 0, 0, 0));

        // Pass 1: 2x3 window, dwell 3, gap 2; bit at (1,1), data at (0,1).
        bit_en = 1; bit_row = 1; bit_col = 1;
        data_en = 1; data_row = 0; data_col = 1;
        bus.row_last = 6'd1; bus.col_last = 6'd2;
        bus.dwell_cycles = 16'd3; bus.gap_cycles = 16'd2;
        bus.col_mode = 1; bus.continuous = 0;
        bus.start = 1;
        step();
        bus.start = 0;
        chk("p1 k0", observed(), model(0, 3, 2, 2, 1, 1));
        for (int k = 1; k <= 37; k++) begin
            step();
            chk($sformatf("p1 k%0d", k), observed(), model(k, 3, 2, 2, 1, 1));
            if (k == 5) bus.start = 1;
            if (k == 6) bus.start = 0;
            if (k == 10) begin
                bus.dwell_cycles = 16'd8;
                bus.col_last = 6'd5;
            end
        end

        // Pass 2: the new dwell 8 / col_last 5 take effect on the next start.
        bus.start = 1;
        step();
        bus.start = 0;
        chk("p2 k0", observed(), model(0, 8, 2, 5, 1, 1));
        for (int k = 1; k <= 40; k++) begin
            step();
            chk($sformatf("p2 k%0d", k), observed(), model(k, 8, 2, 5, 1, 1));
        end
        bus.stop = 1;
        step();
        bus.stop = 0;
        chk("p2 stop", observed(), pack(0, 0, 0, 0, 0, 0, 1));

        // Pass 3: stop in the GAP of (0,1).
        bus.dwell_cycles = 16'd3; bus.col_last = 6'd2;
        bus.start = 1;
        step();
        bus.start = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("p3 k%0d", k), observed(), model(k, 3, 2, 2, 1, 1));
        end
        bus.stop = 1;
        step();
        bus.stop = 0;
        chk("stop in gap", observed(), pack(0, 0, 0, 0, 0, 0, 1));
        step();
        chk("stop no frame_done", observed(), pack(0, 0, 0, 0, 0, 0, 1));
        bus.start = 1; bus.stop = 1;
        step();
        bus.start = 0; bus.stop = 0;
        chk("start+stop idle", observed(), pack(0, 0, 0, 0, 0, 0, 1));
        step();
        chk("start+stop idle next", observed(), pack(0, 0, 0, 0, 0, 0, 1));

        // Pass 4: continuous 1x1, dwell 0, gap 0, bit at (0,0).
        bit_en = 1; bit_row = 0; bit_col = 0; data_en = 0;
        bus.row_last = '0; bus.col_last = '0;
        bus.dwell_cycles = '0; bus.gap_cycles = '0;
        bus.col_mode = 0; bus.continuous = 1;
        bus.start = 1;
        step();
        bus.start = 0;
        chk("p4 k0", observed(), pack(0, 0, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 13; k++) begin
            step();
            chk($sformatf("p4 k%0d", k), observed(),
                pack(0, 0, (k % 2 == 1), 0, 1, (k % 2 == 0), 0));
        end

        // Reset while drive_out is high.
        reset = 1;
        step();
        reset = 0;
        chk("reset mid-fire", observed(), pack(0, 0, 0, 0, 0, 0, 0));
        step();
        chk("after reset", observed(), pack(0, 0, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
